reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 64: number of tracked register IDs (6-bit space; ID 33 is HI/LO).
REQ-002 SHALL have parameter MAX_LAT, default 3: largest short-op latency in cycles.
REQ-003 SHALL have port clk input 1: sole clock, rising edge.
REQ-004 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid input 1: the decode stage presents an instruction.
REQ-006 SHALL have port rd_reg1 input 6: first source register ID (0 = none).
REQ-007 SHALL have port rd_reg2 input 6: second source register ID (0 = none).
REQ-008 SHALL have port wr_reg input 6: destination register ID (0 = none).
REQ-009 SHALL have port wr_lat input 2: cycles until the short-op result is forwardable (0..MAX_LAT).
REQ-010 SHALL have port wr_long input 1: the destination is produced by a multi-cycle MULTU/DIVU op and is cleared only by writeback.
REQ-011 SHALL have port wb_valid input 1: a long-op result is written this cycle.
REQ-012 SHALL have port wb_reg input 6: register ID written by the long op.
REQ-013 SHALL have port flush input 1: squash in-flight short ops.
REQ-014 SHALL have port stall output 1: hold the decode stage this cycle.
REQ-015 SHALL have port issue_fire output 1: issue_valid & ~stall.
REQ-016 SHALL have port long_pending output 1: a long op is outstanding.

Function
REQ-017 SHALL keep, per register ID 1..NREGS-1, a 2-bit countdown cnt and a long flag; ID 0 SHALL never be busy.
REQ-018 SHALL treat a register as busy when cnt!=0 or its long flag is set.
REQ-019 SHALL assert stall combinationally when issue_valid and either source is busy (RAW hazard).
REQ-020 SHALL assert stall when issue_valid and wr_reg has its long flag set (WAW hazard).
REQ-021 SHALL assert stall when issue_valid and wr_long and long_pending (single long unit; structural hazard).
REQ-022 SHALL force stall to 0 when issue_valid=0.
REQ-023 SHALL, on issue_fire with wr_reg!=0, set cnt=wr_lat when wr_long=0, or set the long flag when wr_long=1.
REQ-024 SHALL decrement every nonzero cnt by 1 each cycle; a register with cnt=1 stalls this cycle and is free the next.
REQ-025 SHALL clear the long flag of wb_reg on wb_valid; wb_valid to a register with no long flag set SHALL be ignored.
REQ-026 SHALL give the issue write precedence over decrement and over writeback when both target the same register in the same cycle.
REQ-027 SHALL, on flush, zero all cnt fields in the next cycle, retain the long flags, and produce issue_fire=0 for that cycle.
REQ-028 SHALL drive long_pending as the OR of all long flags, registered.

Reset
REQ-029 SHALL, on rst, asynchronously clear all cnt fields and long flags; stall, issue_fire and long_pending SHALL then read 0.
REQ-030 SHALL discard any issue in flight when rst is asserted mid-operation; no state survives reset.

Configuration
REQ-031 SHALL, when macro SB_WB_BYPASS_EN is defined, treat a register whose long flag is cleared by this cycle's wb_valid as not busy for REQ-019 and REQ-020.
REQ-032 SHALL, when SB_WB_BYPASS_EN is undefined, keep that register busy until the cycle after writeback.

Structure
REQ-033 SHALL take REG_W=6, NREGS, MAX_LAT, REG_HILO=6'd33 and REG_RA=6'd31 from shared package sb_pkg.
REQ-034 SHALL instantiate one sub-module sb_entry (cnt plus long flag, with set, decrement and clear logic) per register ID 1..NREGS-1.

Verification
REQ-035 SHALL cover: issue ADDU wr=8 lat=2, then a reader of rd_reg1=8 -> stall for 2 cycles, then issue_fire.
REQ-036 SHALL cover: issue MULTU wr=33 long, then MFLO rd=33 -> stall until wb_valid wb_reg=33; the stall drops in the wb cycle with SB_WB_BYPASS_EN and one cycle later without it.
REQ-037 SHALL cover: a second DIVU while long_pending=1 -> stall; after wb_valid wb_reg=33 -> issue_fire=1.
REQ-038 SHALL cover: a reader with rd_reg1=0 and rd_reg2=0 during any busy state -> stall=0.
REQ-039 SHALL cover: wr=9 lat=3 followed by flush -> the reader of reg 9 issues in the cycle after flush, and long flags are unchanged.
REQ-040 SHALL cover: rst asserted while reg 5 cnt=2 and reg 33 is long -> all outputs 0 immediately; a reader of 5 or 33 after reset -> issue_fire=1.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants for the register scoreboard: ID width, table size,
// short-op latency bound and the special register IDs.
package sb_pkg;

   localparam int REG_W   = 6;
   localparam int NREGS   = 64;
   localparam int MAX_LAT = 3;

   localparam logic [REG_W-1:0] REG_HILO = 6'd33;
   localparam logic [REG_W-1:0] REG_RA   = 6'd31;

   typedef logic [REG_W-1:0] reg_id_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake bundle between the pipeline (master) and the
// register scoreboard (slave).
interface reg_scoreboard_if;
   import sb_pkg::*;

   logic       issue_valid;
   reg_id_t    rd_reg1;
   reg_id_t    rd_reg2;
   reg_id_t    wr_reg;
   logic [1:0] wr_lat;
   logic       wr_long;
   logic       wb_valid;
   reg_id_t    wb_reg;
   logic       flush;
   logic       stall;
   logic       issue_fire;
   logic       long_pending;

   modport master (
      output issue_valid, rd_reg1, rd_reg2, wr_reg, wr_lat, wr_long,
      output wb_valid, wb_reg, flush,
      input  stall, issue_fire, long_pending
   );

   modport slave (
      input  issue_valid, rd_reg1, rd_reg2, wr_reg, wr_lat, wr_long,
      input  wb_valid, wb_reg, flush,
      output stall, issue_fire, long_pending
   );

endinterface

// File: rtl/sb_entry.sv
// One scoreboard slot: short-op countdown plus long-op flag.
// SB_WB_BYPASS_EN makes a same-cycle writeback release the long flag for hazard checks.
module sb_entry #(
   parameter int MAX_LAT = sb_pkg::MAX_LAT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_set,
   input  logic       i_long,
   input  logic [1:0] i_lat,
   input  logic       i_wb_clr,
   input  logic       i_flush,
   output logic       o_busy,
   output logic       o_waw,
   output logic       o_long_nxt
);

   localparam logic [1:0] LAT_MAX = 2'(MAX_LAT);

   logic [1:0] r_cnt;
   logic       r_long;
   logic [1:0] w_cnt_nxt;
   logic [1:0] w_lat;

   assign w_lat = (i_lat > LAT_MAX) ? LAT_MAX : i_lat;

   // An issue write wins over flush, decrement and writeback on the same slot.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_cnt_nxt  = r_cnt;
      o_long_nxt = r_long;
      if (i_set && !i_long)  w_cnt_nxt = w_lat;
      else if (i_flush)      w_cnt_nxt = '0;
      else if (r_cnt != 2'd0) w_cnt_nxt = r_cnt - 2'd1;

      if (i_set && i_long) o_long_nxt = 1'b1;
      else if (i_wb_clr)   o_long_nxt = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_long <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all slots update together.
         r_cnt  <= w_cnt_nxt;
         r_long <= o_long_nxt;
      end
   end

`ifdef SB_WB_BYPASS_EN
   assign o_waw  = r_long & ~i_wb_clr;
`else
   assign o_waw  = r_long;
`endif
   assign o_busy = (r_cnt != 2'd0) | o_waw;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW/structural hazard detection for a decode stage
// with short pipelined ops and one long MULTU/DIVU unit. Option: SB_WB_BYPASS_EN.
module reg_scoreboard #(
   parameter int NREGS   = sb_pkg::NREGS,
   parameter int MAX_LAT = sb_pkg::MAX_LAT
) (
   input  logic            clk,
   input  logic            rst,
   reg_scoreboard_if.slave sb
);
   import sb_pkg::*;

   logic [NREGS-1:0] w_busy;
   logic [NREGS-1:0] w_waw;
   logic [NREGS-1:0] w_long_nxt;
   logic             w_hazard;
   logic             w_fire;
   logic             r_long_pending;

   // ID 0 is the "no register" encoding and is never busy.
   assign w_busy[0]     = 1'b0;
   assign w_waw[0]      = 1'b0;
   assign w_long_nxt[0] = 1'b0;

   for (genvar i = 1; i < NREGS; i++) begin : g_entry
      sb_entry #(
         .MAX_LAT (MAX_LAT)
      ) u_entry (
         .clk        (clk),
         .rst        (rst),
         .i_set      (w_fire && (sb.wr_reg == REG_W'(i))),
         .i_long     (sb.wr_long),
         .i_lat      (sb.wr_lat),
         .i_wb_clr   (sb.wb_valid && (sb.wb_reg == REG_W'(i))),
         .i_flush    (sb.flush),
         .o_busy     (w_busy[i]),
         .o_waw      (w_waw[i]),
         .o_long_nxt (w_long_nxt[i])
      );
   end

   assign w_hazard = w_busy[sb.rd_reg1] | w_busy[sb.rd_reg2] | w_waw[sb.wr_reg]
                   | (sb.wr_long & r_long_pending);

   // Outputs are gated by rst so they read 0 for the whole reset window.
   assign w_fire        = ~rst & sb.issue_valid & ~w_hazard & ~sb.flush;
   assign sb.stall      = ~rst & sb.issue_valid & w_hazard;
   assign sb.issue_fire = w_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_long_pending <= 1'b0;
      else     r_long_pending <= |w_long_nxt;
   end

   assign sb.long_pending = r_long_pending;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard-queue bench for reg_scoreboard; SB_WB_BYPASS_EN selects
// the writeback-bypass expectations.
module tb_reg_scoreboard;
   import sb_pkg::*;

   typedef struct {
      string      tag;
      logic [2:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   reg_scoreboard_if sbif ();

   reg_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .sb  (sbif)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus, queue its expected {stall, issue_fire, long_pending},
   // then compare on the falling edge and advance past the next rising edge.
   task automatic step(input string tag, input bit r, input bit iv,
                       input int r1, input int r2, input int wr, input int lat, input bit lg,
                       input bit wbv, input int wbr, input bit fl,
                       input bit es, input bit ef, input bit el);
      exp_t       e;
      logic [2:0] obs;
      rst              = r;
      sbif.issue_valid = iv;
      sbif.rd_reg1     = REG_W'(r1);
      sbif.rd_reg2     = REG_W'(r2);
      sbif.wr_reg      = REG_W'(wr);
      sbif.wr_lat      = 2'(lat);
      sbif.wr_long     = lg;
      sbif.wb_valid    = wbv;
      sbif.wb_reg      = REG_W'(wbr);
      sbif.flush       = fl;
      sb_q.push_back('{tag, {es, ef, el}});
      @(negedge clk);
      e   = sb_q.pop_front();
      obs = {sbif.stall, sbif.issue_fire, sbif.long_pending};
      n_assert++;
      assert (obs === e.exp) else begin
         n_fail++;
         $error("FAIL %s: stall/fire/long_pending observed %b expected %b", e.tag, obs, e.exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      //   tag            rst iv r1  r2  wr lat lg wbv wbr fl   st fi lp
      step("reset_hold",   1, 1,  5,  0, 33, 0, 1, 0,  0, 0,  0, 0, 0);
      // short-op RAW: lat 2 gives two stall cycles
      step("addu_w8",      0, 1,  0,  0,  8, 2, 0, 0,  0, 0,  0, 1, 0);
      step("raw8_c1",      0, 1,  8,  0,  0, 0, 0, 0,  0, 0,  1, 0, 0);
      step("raw8_c2",      0, 1,  8,  0,  0, 0, 0, 0,  0, 0,  1, 0, 0);
      step("raw8_free",    0, 1,  8,  0,  0, 0, 0, 0,  0, 0,  0, 1, 0);
      // reader with no sources while reg 8 busy; rd_reg2 path
      step("addu_w8_l3",   0, 1,  0,  0,  8, 3, 0, 0,  0, 0,  0, 1, 0);
      step("no_src_busy",  0, 1,  0,  0, 10, 0, 0, 0,  0, 0,  0, 1, 0);
      step("raw8_rd2",     0, 1,  0,  8,  0, 0, 0, 0,  0, 0,  1, 0, 0);
      step("idle_nostall", 0, 0,  8,  8,  0, 0, 0, 0,  0, 0,  0, 0, 0);
      // MULTU -> MFLO on HI/LO
      step("multu_hilo",   0, 1,  0,  0, 33, 0, 1, 0,  0, 0,  0, 1, 0);
      step("mflo_wait1",   0, 1, 33,  0,  0, 0, 0, 0,  0, 0,  1, 0, 1);
      step("mflo_wait2",   0, 1, 33,  0,  0, 0, 0, 0,  0, 0,  1, 0, 1);
`ifdef SB_WB_BYPASS_EN
      step("mflo_wb_cyc",  0, 1, 33,  0,  0, 0, 0, 1, 33, 0,  0, 1, 1);
`else
      step("mflo_wb_cyc",  0, 1, 33,  0,  0, 0, 0, 1, 33, 0,  1, 0, 1);
`endif
      step("mflo_after",   0, 1, 33,  0,  0, 0, 0, 0,  0, 0,  0, 1, 0);
      // structural hazard on the single long unit
      step("multu_2",      0, 1,  0,  0, 33, 0, 1, 0,  0, 0,  0, 1, 0);
      step("divu_blocked", 0, 1,  0,  0, 33, 0, 1, 0,  0, 0,  1, 0, 1);
      step("divu_wb_cyc",  0, 1,  0,  0, 33, 0, 1, 1, 33, 0,  1, 0, 1);
      step("divu_fires",   0, 1,  0,  0, 33, 0, 1, 0,  0, 0,  0, 1, 0);
      // flush squashes short counts, keeps long flags
      step("addu_w9_l3",   0, 1,  0,  0,  9, 3, 0, 0,  0, 0,  0, 1, 1);
      step("flush_cyc",    0, 1,  9,  0,  0, 0, 0, 0,  0, 1,  1, 0, 1);
      step("raw9_postfl",  0, 1,  9,  0,  0, 0, 0, 0,  0, 0,  0, 1, 1);
      step("long_kept",    0, 1, 33,  0,  0, 0, 0, 0,  0, 0,  1, 0, 1);
      step("flush_nofire", 0, 1,  0,  0,  0, 0, 0, 0,  0, 1,  0, 0, 1);
      step("wb_hilo",      0, 0,  0,  0,  0, 0, 0, 1, 33, 0,  0, 0, 1);
      // reset mid-operation
      step("multu_pre",    0, 1,  0,  0, 33, 0, 1, 0,  0, 0,  0, 1, 0);
      step("addu_w5",      0, 1,  0,  0,  5, 2, 0, 0,  0, 0,  0, 1, 1);
      step("rst_mid",      1, 1,  5, 33, 33, 0, 1, 0,  0, 0,  0, 0, 0);
      step("post_rst_rd",  0, 1,  5, 33,  0, 0, 0, 0,  0, 0,  0, 1, 0);
      step("post_rst_div", 0, 1,  0,  0, 33, 0, 1, 0,  0, 0,  0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
